adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 The block SHALL take parameter width_p, default 24, meaning the signed audio sample width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; the 12.288 MHz audio clock domain.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port sample_valid_i, input, 1 bit: single-cycle sample strobe at 48 kHz.
REQ-005 The block SHALL have port sample_i, input, width_p bits: signed wave sample; valid when sample_valid_i=1.
REQ-006 The block SHALL have port gate_i, input, 1 bit: key held (1) or released (0).
REQ-007 The block SHALL have port attack_rate_i, input, 16 bits: envelope increment per sample in ATTACK.
REQ-008 The block SHALL have port decay_rate_i, input, 16 bits: envelope decrement per sample in DECAY.
REQ-009 The block SHALL have port sustain_level_i, input, 16 bits: SUSTAIN envelope level.
REQ-010 The block SHALL have port release_rate_i, input, 16 bits: envelope decrement per sample in RELEASE.
REQ-011 The block SHALL have port sample_o, output, width_p bits: scaled signed sample to the I2S controller's left/right data inputs.
REQ-012 The block SHALL have port sample_valid_o, output, 1 bit: single-cycle strobe qualifying sample_o.
REQ-013 The block SHALL have port env_o, output, 16 bits: current envelope level.
REQ-014 The block SHALL have port state_o, output, 3 bits: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high whenever state_o != IDLE.

Function
REQ-016 State, env and outputs SHALL change only on cycles where sample_valid_i=1; the exception is sample_valid_o, which SHALL drop the following cycle.
REQ-017 gate_i and all rate/level inputs SHALL be sampled only on sample_valid_i cycles.
REQ-018 In IDLE with gate_i=1, the next state SHALL be ATTACK and env SHALL stay 0 on that tick.
REQ-019 ATTACK: if gate_i=0, the next state SHALL be RELEASE with env unchanged.
REQ-020 ATTACK: otherwise, if env+attack_rate_i >= 0xFFFF (17-bit compare), env SHALL become 0xFFFF and the next state SHALL be DECAY.
REQ-021 ATTACK: otherwise, env SHALL become env+attack_rate_i.
REQ-022 DECAY: if gate_i=0, the next state SHALL be RELEASE.
REQ-023 DECAY: otherwise, if env <= sustain_level_i + decay_rate_i (17-bit compare), env SHALL become sustain_level_i and the next state SHALL be SUSTAIN.
REQ-024 DECAY: otherwise, env SHALL become env-decay_rate_i.
REQ-025 SUSTAIN: env SHALL track sustain_level_i on every tick, and gate_i=0 SHALL move the state to RELEASE.
REQ-026 RELEASE: if gate_i=1, the next state SHALL be ATTACK with env unchanged (retrigger from current level, no reset to 0).
REQ-027 RELEASE: otherwise, if env <= release_rate_i, env SHALL become 0 and the next state SHALL be IDLE.
REQ-028 RELEASE: otherwise, env SHALL become env-release_rate_i.
REQ-029 Env arithmetic SHALL never wrap; any result outside 0..0xFFFF SHALL be clamped by the transition rules above.
REQ-030 gate_i held high in ATTACK, DECAY or SUSTAIN SHALL NOT retrigger (legato).
REQ-031 A rate of 0 SHALL hold env constant in that state with no transition, except gate_i-driven transitions.
REQ-032 sample_o SHALL equal (sample_i * {1'b0, env}) >>> 16, an arithmetic shift of the signed 41-bit product truncated to width_p, using env as it was before that tick's update.
REQ-033 sample_o and sample_valid_o SHALL be registered with exactly 1 clk_i cycle of latency from sample_valid_i.
REQ-034 sample_o SHALL hold its value between strobes.
REQ-035 Back-to-back sample_valid_i strobes on consecutive cycles SHALL each be processed with no drops.

Reset
REQ-036 rst_ni=0 SHALL immediately force state=IDLE, env_o=0, sample_o=0, sample_valid_o=0 and busy_o=0, regardless of clk_i.
REQ-037 Reset asserted mid-envelope SHALL abort the note with no release tail.
REQ-038 After rst_ni rises, the first sample_valid_i SHALL be processed normally.

Verification
REQ-039 Attack: attack_rate_i=0x4000, gate_i=1, five strobes -> env_o 0, 0x4000, 0x8000, 0xC000, 0xFFFF; state_o goes to DECAY on the fifth strobe.
REQ-040 Decay/sustain: env=0xFFFF, decay_rate_i=0x6000, sustain_level_i=0x8000 -> env_o 0x9FFF, then 0x8000; state_o=SUSTAIN; changing sustain_level_i to 0x4000 gives env_o=0x4000 on the next strobe.
REQ-041 Release and retrigger: SUSTAIN at 0x4000, gate_i=0, release_rate_i=0x1800 -> env_o 0x4000, 0x2800, 0x1000, 0 and state IDLE; gate_i=1 at env 0x2800 -> ATTACK starting from 0x2800.
REQ-042 Scaling: env=0x8000, sample_i=0x7FFFFF -> sample_o=0x3FFFFF one cycle later; sample_i=0x800000 -> 0xC00000; env=0 -> sample_o=0.
REQ-043 Reset mid-note: rst_ni pulsed low for 3 cycles between clock edges while in DECAY -> all outputs 0 and state IDLE without waiting for a clock edge.
REQ-044 Strobe timing: strobes on consecutive cycles and on cycles 100 apart -> exactly one sample_valid_o per strobe, each 1 cycle later; gate_i toggled between strobes is ignored.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: advances one step per audio sample strobe and
// scales the incoming signed sample by the pre-update envelope level.
module adsr_envelope #(
  parameter int width_p = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sample_valid_i,
  input  logic signed [width_p-1:0] sample_i,
  input  logic                      gate_i,
  input  logic        [15:0]        attack_rate_i,
  input  logic        [15:0]        decay_rate_i,
  input  logic        [15:0]        sustain_level_i,
  input  logic        [15:0]        release_rate_i,
  output logic signed [width_p-1:0] sample_o,
  output logic                      sample_valid_o,
  output logic        [15:0]        env_o,
  output logic        [2:0]         state_o,
  output logic                      busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                      state_p1;
  logic        [15:0]          env_p1;
  logic signed [width_p-1:0]   sample_p1;
  logic                        vld_p1;

  // Envelope is an unsigned Q0.16 gain; zero-extend it so the product stays signed.
  function automatic logic signed [width_p-1:0] scale_sample(
    input logic signed [width_p-1:0] smp,
    input logic        [15:0]        env
  );
    logic signed [width_p+16:0] smp_x;
    logic signed [width_p+16:0] env_x;
    logic signed [width_p+16:0] prod;
    smp_x = {{17{smp[width_p-1]}}, smp};
    env_x = {{(width_p+1){1'b0}}, env};
    prod  = smp_x * env_x;
    prod  = prod >>> 16;
    return prod[width_p-1:0];
  endfunction

  function automatic logic attack_saturates(
    input logic [15:0] env,
    input logic [15:0] rate
  );
    logic [16:0] sum;
    sum = {1'b0, env} + {1'b0, rate};
    return (sum >= 17'h0_FFFF);
  endfunction

  function automatic logic floor_reached(
    input logic [15:0] env,
    input logic [15:0] floor_lvl,
    input logic [15:0] rate
  );
    logic [16:0] limit;
    limit = {1'b0, floor_lvl} + {1'b0, rate};
    return ({1'b0, env} <= limit);
  endfunction

  // Stage p1: state, envelope and scaled sample all register on the strobe edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p1  <= IDLE;
      env_p1    <= '0;
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= sample_valid_i;
      if (sample_valid_i) begin
        sample_p1 <= scale_sample(sample_i, env_p1);
        case (state_p1)
          IDLE: begin
            if (gate_i) state_p1 <= ATTACK;
          end
          ATTACK: begin
            if (!gate_i) begin
              state_p1 <= RELEASE;
            end else if (attack_rate_i != '0) begin
              if (attack_saturates(env_p1, attack_rate_i)) begin
                env_p1   <= 16'hFFFF;
                state_p1 <= DECAY;
              end else begin
                env_p1 <= env_p1 + attack_rate_i;
              end
            end
          end
          DECAY: begin
            if (!gate_i) begin
              state_p1 <= RELEASE;
            end else if (decay_rate_i != '0) begin
              if (floor_reached(env_p1, sustain_level_i, decay_rate_i)) begin
                env_p1   <= sustain_level_i;
                state_p1 <= SUSTAIN;
              end else begin
                env_p1 <= env_p1 - decay_rate_i;
              end
            end
          end
          SUSTAIN: begin
            env_p1 <= sustain_level_i;
            if (!gate_i) state_p1 <= RELEASE;
          end
          RELEASE: begin
            // Retrigger keeps the current level so the attack ramps without a click.
            if (gate_i) begin
              state_p1 <= ATTACK;
            end else if (release_rate_i != '0) begin
              if (floor_reached(env_p1, 16'h0000, release_rate_i)) begin
                env_p1   <= '0;
                state_p1 <= IDLE;
              end else begin
                env_p1 <= env_p1 - release_rate_i;
              end
            end
          end
          default: begin
            state_p1 <= IDLE;
            env_p1   <= '0;
          end
        endcase
      end
    end
  end

  assign sample_o       = sample_p1;
  assign sample_valid_o = vld_p1;
  assign env_o          = env_p1;
  assign state_o        = state_p1;
  assign busy_o         = (state_p1 != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: directed envelope walks, reset abort,
// strobe spacing and a randomized run against an integer reference model.
module tb_adsr_envelope;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic signed [23:0] sample_in;
  logic               gate;
  logic        [15:0] ar, dr, sl, rr;
  logic        [23:0] sample_out;
  logic               sv_out;
  logic        [15:0] env_out;
  logic        [2:0]  state_out;
  logic               busy_out;

  adsr_envelope #(.width_p(24)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_valid_i (valid),
    .sample_i       (sample_in),
    .gate_i         (gate),
    .attack_rate_i  (ar),
    .decay_rate_i   (dr),
    .sustain_level_i(sl),
    .release_rate_i (rr),
    .sample_o       (sample_out),
    .sample_valid_o (sv_out),
    .env_o          (env_out),
    .state_o        (state_out),
    .busy_o         (busy_out)
  );

  typedef struct {
    logic [23:0] smp;
    int          env;
    int          st;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          nstrobe = 0;
  int          vcount = 0;
  int          m_env = 0;
  int          m_state = 0;
  logic [23:0] last_smp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: envelope as a plain integer in 0..65535, states numbered as on state_o.
  task automatic model_step(input logic g, input logic signed [23:0] s, output exp_t e);
    longint p;
    int a, d, lvl, r;
    a = int'(ar); d = int'(dr); lvl = int'(sl); r = int'(rr);
    p = (longint'(s) * longint'(m_env)) >>> 16;
    e.smp = p[23:0];
    if (m_state == 0) begin
      if (g) m_state = 1;
    end else if (m_state == 1) begin
      if (!g) m_state = 4;
      else if (a != 0) begin
        if (m_env + a >= 65535) begin m_env = 65535; m_state = 2; end
        else m_env = m_env + a;
      end
    end else if (m_state == 2) begin
      if (!g) m_state = 4;
      else if (d != 0) begin
        if (m_env <= lvl + d) begin m_env = lvl; m_state = 3; end
        else m_env = m_env - d;
      end
    end else if (m_state == 3) begin
      m_env = lvl;
      if (!g) m_state = 4;
    end else begin
      if (g) m_state = 1;
      else if (r != 0) begin
        if (m_env <= r) begin m_env = 0; m_state = 0; end
        else m_env = m_env - r;
      end
    end
    e.env = m_env;
    e.st  = m_state;
  endtask

  task automatic do_strobe(input logic g, input logic signed [23:0] s);
    exp_t e;
    gate      = g;
    sample_in = s;
    valid     = 1'b1;
    model_step(g, s, e);
    e.due = cyc + 1;
    q.push_back(e);
    nstrobe++;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      gate = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one popped expectation per output strobe, hold check otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sv_out) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(sv_out), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          vcount++;
          check("latency", 32'(cyc), 32'(e.due));
          check("sample_o", 32'(sample_out), 32'(e.smp));
          check("env_o", 32'(env_out), 32'(e.env));
          check("state_o", 32'(state_out), 32'(e.st));
          check("busy_o", 32'(busy_out), 32'(e.st != 0));
          last_smp = e.smp;
        end
      end else begin
        check("sample_hold", 32'(sample_out), 32'(last_smp));
      end
    end
  end

  initial begin
    int exp_att[5];
    logic g_r;
    exp_att = '{0, 32'h4000, 32'h8000, 32'hC000, 32'hFFFF};
    rst_n = 1'b0; valid = 1'b0; gate = 1'b0; sample_in = '0;
    ar = '0; dr = '0; sl = '0; rr = '0;
    #1;
    check("rst_env", 32'(env_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_valid", 32'(sv_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    ar = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      do_strobe(1'b1, 24'($urandom));
      check("attack_env", 32'(env_out), 32'(exp_att[i]));
    end
    check("attack_to_decay", 32'(state_out), 32'd2);

    dr = 16'h6000; sl = 16'h8000;
    do_strobe(1'b1, 24'($urandom));
    check("decay_env1", 32'(env_out), 32'h9FFF);
    do_strobe(1'b1, 24'($urandom));
    check("decay_env2", 32'(env_out), 32'h8000);
    check("sustain_state", 32'(state_out), 32'd3);

    do_strobe(1'b1, 24'h7FFFFF);
    check("scale_pos", 32'(sample_out), 32'h3FFFFF);
    do_strobe(1'b1, 24'h800000);
    check("scale_neg", 32'(sample_out), 32'hC00000);

    sl = 16'h4000;
    do_strobe(1'b1, 24'($urandom));
    check("sustain_track", 32'(env_out), 32'h4000);

    rr = 16'h1800;
    do_strobe(1'b0, 24'($urandom));
    check("rel_env0", 32'(env_out), 32'h4000);
    check("rel_state", 32'(state_out), 32'd4);
    do_strobe(1'b0, 24'($urandom));
    check("rel_env1", 32'(env_out), 32'h2800);
    do_strobe(1'b0, 24'($urandom));
    check("rel_env2", 32'(env_out), 32'h1000);
    do_strobe(1'b0, 24'($urandom));
    check("rel_env3", 32'(env_out), 32'd0);
    check("rel_idle", 32'(state_out), 32'd0);
    do_strobe(1'b0, 24'h7FFFFF);
    check("scale_zero", 32'(sample_out), 32'd0);

    ar = 16'h4000;
    do_strobe(1'b1, 24'($urandom));
    do_strobe(1'b1, 24'($urandom));
    do_strobe(1'b0, 24'($urandom));
    do_strobe(1'b0, 24'($urandom));
    check("retrig_pre", 32'(env_out), 32'h2800);
    do_strobe(1'b1, 24'($urandom));
    check("retrig_state", 32'(state_out), 32'd1);
    check("retrig_env", 32'(env_out), 32'h2800);
    do_strobe(1'b1, 24'($urandom));
    check("retrig_ramp", 32'(env_out), 32'h6800);

    gap(99);
    do_strobe(1'b1, 24'($urandom));
    gap(99);
    ar = 16'hFFFF;
    do_strobe(1'b1, 24'($urandom));
    check("to_decay", 32'(state_out), 32'd2);
    dr = 16'h0100; sl = 16'h1000;
    do_strobe(1'b1, 24'($urandom));
    check("decay_step", 32'(env_out), 32'hFEFF);

    #2;
    rst_n = 1'b0;
    nstrobe -= q.size();
    q.delete();
    m_env = 0; m_state = 0; last_smp = '0;
    #1;
    check("abort_env", 32'(env_out), 32'd0);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_sample", 32'(sample_out), 32'd0);
    check("abort_valid", 32'(sv_out), 32'd0);
    check("abort_busy", 32'(busy_out), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_strobe(1'b1, 24'($urandom));
    check("post_rst_state", 32'(state_out), 32'd1);

    g_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) g_r = ~g_r;
      if ($urandom_range(0, 29) == 0) begin
        ar = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
        dr = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
        rr = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
        sl = 16'($urandom);
      end
      do_strobe(g_r, 24'($urandom));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 4));
    end

    gap(5);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("strobe_count", 32'(vcount), 32'(nstrobe));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
